// File: rtl/fpu_dp_pkg.sv
// rtl/fpu_dp_pkg.sv - shared widths, limits and state encoding for the sequential DP subtractor
package fpu_dp_pkg;

  localparam int EXP_W     = 11;
  localparam int MAN_W     = 52;
  localparam int EXP_MAX   = 2047;
  localparam int ALIGN_CAP = 54;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    OP,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fpu_comparator.sv
// rtl/fpu_comparator.sv - unsigned magnitude comparator returning |x - y| plus ordering flags
module fpu_comparator #(
  parameter int W = 11
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         x_gt,
  output logic         eq
);

  always_comb begin
    x_gt = (x > y);
    eq   = (x == y);
    diff = x_gt ? (x - y) : (y - x);
  end

endmodule

// File: rtl/fpu_dp_subtractor_seq.sv
// rtl/fpu_dp_subtractor_seq.sv - multi-cycle double-precision a - b with bit-serial align and normalize
module fpu_dp_subtractor_seq
  import fpu_dp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        overflow,
  output logic        underflow
);

  state_t             state;
  logic [53:0]        op1_m;
  logic [53:0]        op2_m;
  logic [53:0]        sum_r;
  logic               sign1;
  logic               sign2;
  logic [EXP_W-1:0]   exp_r;
  logic [5:0]         cnt;

  logic [EXP_W-1:0]   exp_diff;
  logic               a_exp_gt;
  logic               exp_eq;
  logic               a_is_op1;
  logic [EXP_W:0]     exp_inc;

  fpu_comparator #(.W(EXP_W)) u_exp_cmp (
    .x    (a[EXP_W+MAN_W-1:MAN_W]),
    .y    (b[EXP_W+MAN_W-1:MAN_W]),
    .diff (exp_diff),
    .x_gt (a_exp_gt),
    .eq   (exp_eq)
  );

  // Full tie keeps a as op1, so a - a always produces a non-negative magnitude path.
  assign a_is_op1 = a_exp_gt | (exp_eq & (a[MAN_W-1:0] >= b[MAN_W-1:0]));
  assign exp_inc  = {1'b0, exp_r} + 12'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      op1_m     <= '0;
      op2_m     <= '0;
      sum_r     <= '0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      exp_r     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (a_is_op1) begin
              op1_m <= {2'b01, a[MAN_W-1:0]};
              op2_m <= {2'b01, b[MAN_W-1:0]};
              sign1 <= a[63];
              sign2 <= ~b[63];
              exp_r <= a[EXP_W+MAN_W-1:MAN_W];
            end else begin
              op1_m <= {2'b01, b[MAN_W-1:0]};
              op2_m <= {2'b01, a[MAN_W-1:0]};
              sign1 <= ~b[63];
              sign2 <= a[63];
              exp_r <= b[EXP_W+MAN_W-1:MAN_W];
            end
            cnt   <= (exp_diff > EXP_W'(ALIGN_CAP)) ? 6'(ALIGN_CAP) : exp_diff[5:0];
            state <= ALIGN;
          end
        end

        ALIGN: begin
          if (cnt == 6'd0) begin
            state <= OP;
          end else begin
            op2_m <= op2_m >> 1;
            cnt   <= cnt - 6'd1;
          end
        end

        OP: begin
          sum_r <= (sign1 == sign2) ? (op1_m + op2_m) : (op1_m - op2_m);
          state <= NORM;
        end

        NORM: begin
          if (sum_r == '0) begin
            result <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (sum_r[53]) begin
            sum_r <= sum_r >> 1;
            exp_r <= exp_inc[EXP_W-1:0];
            if (exp_inc == 12'(EXP_MAX)) begin
              overflow <= 1'b1;
              result   <= {sign1, 11'h7FF, 52'b0};
              done     <= 1'b1;
              state    <= DONE;
            end
          end else if (sum_r[52]) begin
            result <= {sign1, exp_r, sum_r[MAN_W-1:0]};
            done   <= 1'b1;
            state  <= DONE;
          end else if (exp_r == 11'd1) begin
            underflow <= 1'b1;
            result    <= {sign1, 63'b0};
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            sum_r <= sum_r << 1;
            exp_r <= exp_r - 11'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dp_subtractor_seq.sv
// tb/tb_fpu_dp_subtractor_seq.sv - directed self-checking bench for fpu_dp_subtractor_seq
module tb_fpu_dp_subtractor_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        overflow;
  logic        underflow;

  int checks;
  int errors;

  fpu_dp_subtractor_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation and returns the cycle in which done is seen (-1 if never).
  task automatic run_op(input logic [63:0] av, input logic [63:0] bv, output int cyc);
    bit found;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    if (!found) cyc = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", underflow); end
    rst = 1'b0;
  endtask

  task automatic test_sub_basic;
    int cyc;
    run_op(64'h4008000000000000, 64'h3FF0000000000000, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL sub3m1_cycle: got %0d expected 5", cyc); end
    checks++; if (result !== 64'h4000000000000000) begin errors++; $display("FAIL sub3m1_result: got %h expected 4000000000000000", result); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL sub3m1_flags: got %b expected 00", {overflow, underflow}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_done: got %b expected 0", busy); end
    checks++; if (result !== 64'h4000000000000000) begin errors++; $display("FAIL result_held: got %h expected 4000000000000000", result); end
  endtask

  task automatic test_zero;
    int cyc;
    run_op(64'h3FF0000000000000, 64'h3FF0000000000000, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL zero_cycle: got %0d expected 4", cyc); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL zero_result: got %h expected 0", result); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL zero_flags: got %b expected 00", {overflow, underflow}); end
  endtask

  task automatic test_eff_add;
    int cyc;
    run_op(64'h3FF0000000000000, 64'hBFF0000000000000, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL effadd_cycle: got %0d expected 5", cyc); end
    checks++; if (result !== 64'h4000000000000000) begin errors++; $display("FAIL effadd_result: got %h expected 4000000000000000", result); end
  endtask

  task automatic test_overflow;
    int cyc;
    run_op(64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL ovf_timeout: got %0d expected done", cyc); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ovf_unf: got %b expected 0", underflow); end
    checks++; if (result !== 64'h7FF0000000000000) begin errors++; $display("FAIL ovf_result: got %h expected 7ff0000000000000", result); end
    // A held result and flag must both be cleared by reset.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset_flag: got %b expected 0", overflow); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL ovf_reset_result: got %h expected 0", result); end
  endtask

  task automatic test_underflow;
    int cyc;
    run_op(64'h0010000000000001, 64'h0010000000000000, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL unf_cycle: got %0d expected 4", cyc); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b expected 1", underflow); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL unf_result: got %h expected 0", result); end
  endtask

  task automatic test_cap_busy;
    int cyc;
    bit found;
    @(negedge clk);
    a = 64'h3FF0000000000000;
    b = 64'h3C30000000000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (cyc == 10) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cap_busy: got %b expected 1", busy); end
        a = 64'h4008000000000000;
        b = 64'h3FF0000000000000;
        start = 1'b1;
      end
      if (cyc == 11) start = 1'b0;
      if (done) found = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    checks++; if (cyc !== 58) begin errors++; $display("FAIL cap_cycle: got %0d expected 58", cyc); end
    checks++; if (result !== 64'h3FF0000000000000) begin errors++; $display("FAIL cap_result: got %h expected 3ff0000000000000", result); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    a = 64'h3FF0000000000000;
    b = 64'h3C30000000000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL midrst_result: got %h expected 0", result); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b expected 00", {overflow, underflow}); end
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_after_reset;
    int cyc;
    run_op(64'h4008000000000000, 64'h3FF0000000000000, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL post_rst_cycle: got %0d expected 5", cyc); end
    checks++; if (result !== 64'h4000000000000000) begin errors++; $display("FAIL post_rst_result: got %h expected 4000000000000000", result); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit found;
    @(negedge clk);
    a = 64'h4008000000000000;
    b = 64'h3FF0000000000000;
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 5", cyc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_in_done: got %b expected 1", busy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 00", {busy, done}); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got %b expected 1", busy); end
    start = 1'b0;
    cyc = 7;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (done) found = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    checks++; if (cyc !== 11) begin errors++; $display("FAIL b2b_second_cycle: got %0d expected 11", cyc); end
    checks++; if (result !== 64'h4000000000000000) begin errors++; $display("FAIL b2b_result: got %h expected 4000000000000000", result); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    test_reset;
    test_sub_basic;
    test_zero;
    test_eff_add;
    test_overflow;
    test_underflow;
    test_cap_busy;
    test_reset_mid;
    test_after_reset;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
